// File: rtl/uart_pin_assembler_pkg.sv
// Shared constants and types for the keypad PIN assembler: ASCII codes,
// error causes, FSM states and byte-classification helpers.
package uart_pin_assembler_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ERR_EMPTY   = 2'd0,
        ERR_SHORT   = 2'd1,
        ERR_BADCHAR = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_FAIL    = 2'd3
    } state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_HASH) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/uart_pin_assembler_if.sv
// Byte-input / PIN-output bundle between uart_rx, the assembler and the lock controller.
interface uart_pin_assembler_if
    import uart_pin_assembler_pkg::*;
    #(parameter int N_DIGITS = 4);

    logic                    enable;
    logic [7:0]              rx_data;
    logic                    rx_finished;
    logic [4*N_DIGITS-1:0]   code;
    logic                    code_valid;
    logic                    code_error;
    err_cause_e              err_cause;
    logic [3:0]              digit_count;
    logic                    busy;

    modport master (
        output enable, rx_data, rx_finished,
        input  code, code_valid, code_error, err_cause, digit_count, busy
    );

    modport slave (
        input  enable, rx_data, rx_finished,
        output code, code_valid, code_error, err_cause, digit_count, busy
    );

endinterface

// File: rtl/uart_pin_assembler_timeout_counter.sv
// Idle-cycle counter: counts enabled cycles and flags the last one, restarting
// from zero at that point so it never wraps.
module timeout_counter #(
    parameter int MAX = 1000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    // Count register: clear has priority over counting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= {W{1'b0}};
        end else if (i_clear) begin
            r_count <= {W{1'b0}};
        end else if (i_enable) begin
            if (o_expired) begin
                r_count <= {W{1'b0}};
            end else begin
                r_count <= r_count + W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/uart_pin_assembler.sv
// Assembles ASCII keypad digits from uart_rx into a packed BCD PIN and reports
// completion or the reason an entry was aborted.
module uart_pin_assembler
    import uart_pin_assembler_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_pin_assembler_if.slave  io_bus
);

    localparam int CW = 4 * N_DIGITS;

    state_e      r_state, w_next_state;
    err_cause_e  r_cause, w_fail_cause, w_cause_nxt;
    logic [CW-1:0] r_digits, r_code, w_digits_nxt, w_code_nxt;
    logic [3:0]  r_count, w_count_nxt;
    logic        r_prev_fin, r_valid, r_error, r_busy;
    logic        w_byte_acc, w_is_digit, w_timer_expired;

    // A byte counts only on the rising edge of finished, and only while enabled.
    assign w_byte_acc = io_bus.rx_finished & ~r_prev_fin & io_bus.enable;
    assign w_is_digit = is_digit(io_bus.rx_data);

    timeout_counter #(.MAX(TIMEOUT_CYCLES)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_byte_acc | (r_state != ST_COLLECT)),
        .i_enable  (io_bus.enable & (r_state == ST_COLLECT)),
        .o_expired (w_timer_expired)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an accepted byte always beats the timeout.
    always_comb begin
        w_next_state = r_state;
        w_fail_cause = ERR_EMPTY;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_acc && w_is_digit) begin
                    w_next_state = ST_COLLECT;
                end else if (w_byte_acc && is_term(io_bus.rx_data)) begin
                    w_next_state = ST_FAIL;
                    w_fail_cause = ERR_EMPTY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (w_byte_acc) begin
                    if (w_is_digit) begin
                        if (r_count < 4'(N_DIGITS)) begin
                            w_next_state = ST_COLLECT;
                        end else begin
                            w_next_state = ST_FAIL;
                            w_fail_cause = ERR_BADCHAR;
                        end
                    end else if (is_term(io_bus.rx_data)) begin
                        if (r_count == 4'(N_DIGITS)) begin
                            w_next_state = ST_EMIT;
                        end else begin
                            w_next_state = ST_FAIL;
                            w_fail_cause = ERR_SHORT;
                        end
                    end else if (io_bus.rx_data == ASCII_STAR) begin
                        w_next_state = ST_IDLE;
                    end else if (io_bus.rx_data == ASCII_LF) begin
                        w_next_state = ST_COLLECT;
                    end else begin
                        w_next_state = ST_FAIL;
                        w_fail_cause = ERR_BADCHAR;
                    end
                end else if (io_bus.enable && w_timer_expired) begin
                    w_next_state = ST_FAIL;
                    w_fail_cause = ERR_TIMEOUT;
                end else begin
                    w_next_state = ST_COLLECT;
                end
            end
            ST_EMIT: w_next_state = ST_IDLE;
            ST_FAIL: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath next values; the buffer is always empty in IDLE, so the first digit shifts into zeros.
    always_comb begin
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        w_code_nxt   = r_code;
        w_cause_nxt  = r_cause;
        case (w_next_state)
            ST_COLLECT: begin
                if (w_byte_acc && w_is_digit) begin
                    w_digits_nxt = (r_digits << 3'd4) | CW'(io_bus.rx_data[3:0]);
                    w_count_nxt  = r_count + 4'd1;
                end else begin
                    w_digits_nxt = r_digits;
                    w_count_nxt  = r_count;
                end
            end
            ST_EMIT: begin
                w_code_nxt   = r_digits;
                w_digits_nxt = {CW{1'b0}};
                w_count_nxt  = 4'd0;
            end
            ST_FAIL: begin
                w_cause_nxt  = w_fail_cause;
                w_digits_nxt = {CW{1'b0}};
                w_count_nxt  = 4'd0;
            end
            default: begin
                w_digits_nxt = {CW{1'b0}};
                w_count_nxt  = 4'd0;
            end
        endcase
    end

    // Registered datapath and outputs; the edge-detect history resets high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_fin <= 1'b1;
            r_digits   <= {CW{1'b0}};
            r_count    <= 4'd0;
            r_code     <= {CW{1'b0}};
            r_cause    <= ERR_EMPTY;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_prev_fin <= io_bus.rx_finished;
            r_digits   <= w_digits_nxt;
            r_count    <= w_count_nxt;
            r_code     <= w_code_nxt;
            r_cause    <= w_cause_nxt;
            r_valid    <= (w_next_state == ST_EMIT);
            r_error    <= (w_next_state == ST_FAIL);
            r_busy     <= (w_next_state == ST_COLLECT);
        end
    end

    assign io_bus.code        = r_code;
    assign io_bus.code_valid  = r_valid;
    assign io_bus.code_error  = r_error;
    assign io_bus.err_cause   = r_cause;
    assign io_bus.digit_count = r_count;
    assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_uart_pin_assembler.sv
// Self-checking bench for uart_pin_assembler: vector table, timing sequences
// and randomized byte streams against a byte-level reference model.
module tb_uart_pin_assembler;
    import uart_pin_assembler_pkg::*;

    localparam int N  = 4;
    localparam int TO = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_pin_assembler_if #(.N_DIGITS(N)) bus ();

    uart_pin_assembler #(.N_DIGITS(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] code;
        logic [1:0]  cause;
    } ev_t;

    typedef struct {
        string       s;
        int          hold;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_code;
        logic [1:0]  exp_cause;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n_valid, n_err;
    logic [15:0] last_code;
    logic [1:0]  last_cause;
    bit   rec_on = 1'b0;
    ev_t  act_q[$];
    ev_t  exp_q[$];
    bit   m_col;
    int   m_digits[$];

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.code_valid === 1'b1) begin
            n_valid++;
            last_code = bus.code;
            if (rec_on) act_q.push_back('{1'b0, bus.code, 2'd0});
        end
        if (bus.code_error === 1'b1) begin
            n_err++;
            last_cause = bus.err_cause;
            if (rec_on) act_q.push_back('{1'b1, 16'h0, bus.err_cause});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input byte b, input int hold, input int gap);
        @(posedge clk);
        #1;
        bus.rx_data     = b;
        bus.rx_finished = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.rx_finished = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // Reference model: keypad entry rules applied byte by byte.
    function automatic void model(input byte b);
        logic [15:0] c;
        bit dig, term;
        dig  = (b >= "0") && (b <= "9");
        term = (b == "#") || (b == 8'h0D);
        if (!m_col) begin
            if (dig) begin
                m_col = 1'b1;
                m_digits.delete();
                m_digits.push_back(int'(b) - 48);
            end else if (term) begin
                exp_q.push_back('{1'b1, 16'h0, 2'd0});
            end
        end else if (dig) begin
            if (m_digits.size() < N) begin
                m_digits.push_back(int'(b) - 48);
            end else begin
                exp_q.push_back('{1'b1, 16'h0, 2'd2});
                m_col = 1'b0;
            end
        end else if (term) begin
            if (m_digits.size() == N) begin
                c = 16'h0;
                foreach (m_digits[i]) c = c * 16 + 16'(m_digits[i]);
                exp_q.push_back('{1'b0, c, 2'd0});
            end else begin
                exp_q.push_back('{1'b1, 16'h0, 2'd1});
            end
            m_col = 1'b0;
        end else if (b == "*") begin
            m_col = 1'b0;
        end else if (b != 8'h0A) begin
            exp_q.push_back('{1'b1, 16'h0, 2'd2});
            m_col = 1'b0;
        end
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   k;
        byte  b;
        int   r;
        int   ncmp;

        tbl[0] = '{"1234#",        1,  1, 0, 16'h1234, 2'd0};
        tbl[1] = '{"98\r\n",       1,  0, 1, 16'h1234, 2'd1};
        tbl[2] = '{"12345",        1,  0, 1, 16'h1234, 2'd2};
        tbl[3] = '{"#",            1,  0, 1, 16'h1234, 2'd0};
        tbl[4] = '{"5*4321#",      10, 1, 0, 16'h4321, 2'd0};
        tbl[5] = '{"\n*12\n34\r",  2,  1, 0, 16'h1234, 2'd0};

        // Reset with finished already high: must not count as a byte after release.
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.rx_data = "#";
        bus.rx_finished = 1'b1;
        n_valid = 0;
        n_err = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_code", bus.code, 32'h0);
        check("reset_pulses", {bus.code_valid, bus.code_error}, 32'h0);
        check("reset_cause_cnt_busy", {bus.err_cause, bus.digit_count, bus.busy}, 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.rx_finished = 1'b0;
        repeat (5) @(posedge clk);
        check("finished_high_at_release", n_err + n_valid, 32'd0);

        // Vector table.
        foreach (tbl[v]) begin
            n_valid = 0;
            n_err = 0;
            for (int j = 0; j < tbl[v].s.len(); j++) send(tbl[v].s[j], tbl[v].hold, 6);
            repeat (3) @(posedge clk);
            check($sformatf("vec%0d_valid_count", v), n_valid, tbl[v].exp_valid);
            check($sformatf("vec%0d_error_count", v), n_err, tbl[v].exp_err);
            check($sformatf("vec%0d_code", v), bus.code, tbl[v].exp_code);
            if (tbl[v].exp_err > 0) check($sformatf("vec%0d_cause", v), last_cause, tbl[v].exp_cause);
        end

        // Timeout exactly TO edges after the accepting edge.
        n_err = 0;
        send("7", 1, 0);
        k = 0;
        for (int i = 1; i <= 3000 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.code_error === 1'b1) k = i;
        end
        check("timeout_latency", k, 32'd1000);
        check("timeout_cause", bus.err_cause, 32'd3);

        // Same with enable low for 500 of those cycles.
        repeat (5) @(posedge clk);
        send("7", 1, 0);
        k = 0;
        for (int i = 1; i <= 3000 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.code_error === 1'b1) k = i;
            if (i == 200) bus.enable = 1'b0;
            if (i == 700) bus.enable = 1'b1;
        end
        check("timeout_latency_paused", k, 32'd1500);

        // Bytes are dropped while disabled.
        repeat (5) @(posedge clk);
        n_err = 0;
        bus.enable = 1'b0;
        send("#", 1, 5);
        bus.enable = 1'b1;
        repeat (5) @(posedge clk);
        check("disabled_byte_dropped", n_err, 32'd0);

        // Reset mid-entry.
        send("1", 1, 5);
        send("2", 1, 5);
        #1;
        check("mid_entry_busy_count", {bus.busy, bus.digit_count}, {27'h0, 1'b1, 4'd2});
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_valid = 0;
        n_err = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_code", bus.code, 32'h0);
        check("midreset_state", {bus.code_valid, bus.code_error, bus.err_cause, bus.digit_count, bus.busy}, 32'h0);
        repeat (5) @(posedge clk);
        check("midreset_no_pulse", n_valid + n_err, 32'd0);
        send("0", 1, 5);
        send("0", 1, 5);
        send("0", 1, 5);
        send("0", 1, 5);
        send("#", 1, 5);
        check("zero_pin_valid", n_valid, 32'd1);
        check("zero_pin_code", bus.code, 32'h0);

        // Randomized byte stream against the model.
        rec_on = 1'b1;
        m_col = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10)       b = byte'(8'h30 + $urandom_range(0, 9));
            else if (r < 12)  b = "#";
            else if (r == 12) b = 8'h0D;
            else if (r == 13) b = 8'h0A;
            else if (r == 14) b = "*";
            else              b = byte'(8'h41 + $urandom_range(0, 5));
            model(b);
            send(b, $urandom_range(1, 3), $urandom_range(2, 20));
        end
        repeat (10) @(posedge clk);
        rec_on = 1'b0;
        check("rand_event_count", act_q.size(), exp_q.size());
        ncmp = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) begin
            check($sformatf("rand_ev%0d_kind", i), act_q[i].is_err, exp_q[i].is_err);
            if (exp_q[i].is_err) check($sformatf("rand_ev%0d_cause", i), act_q[i].cause, exp_q[i].cause);
            else                 check($sformatf("rand_ev%0d_code", i), act_q[i].code, exp_q[i].code);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
